// File: rtl/ps2_keymatrix.sv
// rtl/ps2_keymatrix.sv - PS/2 keyboard receiver and CPC key-matrix bus writer
`timescale 1ns/1ps
module ps2_keymatrix #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       busclk_i,
    input  logic       nreset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [8:0] map_addr_o,
    input  logic [7:0] map_data_i,
    output logic       bus_req_o,
    input  logic       bus_gnt_i,
    output logic [3:0] A_o,
    output logic [7:0] D_o,
    output logic       nWR_o,
    output logic       frame_err_o,
    output logic       overflow_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, REQ, WR_ROW, GAP, WR_CMT, DONE} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic [3:0]    bitcnt_q;
    logic [7:0]    sr_q;
    logic          par_q;
    logic [TW-1:0] tcnt_q;
    logic          err_q, ovf_q;
    logic          buf_full_q;
    logic [7:0]    buf_q;

    logic fall, dat_s, par_ok, timeout, rx_done, rx_bad, pop;

    assign dat_s   = dat_sync_q[1];
    assign par_ok  = ^{sr_q, par_q};
    assign fall    = filt_q && !clk_sync_q[1] && (fcnt_q == FW'(FILTER_LEN - 1));
    assign timeout = !fall && (bitcnt_q != 4'd0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign rx_done = fall && (bitcnt_q == 4'd10) && dat_s && par_ok;
    assign rx_bad  = timeout
                   || (fall && (bitcnt_q == 4'd0) && dat_s)
                   || (fall && (bitcnt_q == 4'd10) && !(dat_s && par_ok));

    // Filtered clk only follows the synchronised line after FILTER_LEN agreeing samples.
    always_ff @(posedge busclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            if (clk_sync_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge busclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            bitcnt_q   <= '0;
            sr_q       <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
        end else begin
            err_q <= rx_bad;
            ovf_q <= rx_done && buf_full_q;
            if (fall) begin
                tcnt_q <= '0;
                case (bitcnt_q)
                    4'd0:    if (!dat_s) bitcnt_q <= 4'd1;
                    4'd9:    begin par_q <= dat_s; bitcnt_q <= 4'd10; end
                    4'd10:   bitcnt_q <= 4'd0;
                    default: begin sr_q <= {dat_s, sr_q[7:1]}; bitcnt_q <= bitcnt_q + 4'd1; end
                endcase
            end else if (timeout) begin
                bitcnt_q <= '0;
                tcnt_q   <= '0;
            end else if (bitcnt_q != 4'd0) begin
                tcnt_q <= tcnt_q + TW'(1);
            end else begin
                tcnt_q <= '0;
            end
            if (rx_done && !buf_full_q) begin
                buf_q      <= sr_q;
                buf_full_q <= 1'b1;
            end else if (pop) begin
                buf_full_q <= 1'b0;
            end
        end
    end

    state_t      state_q, state_d;
    logic        ext_q, ext_d, brk_q, brk_d, clr_q, clr_d;
    logic [2:0]  skip_q, skip_d;
    logic [3:0]  row_q, row_d;
    logic [7:0]  rowbyte_q, rowbyte_d;
    logic [8:0]  maddr_q, maddr_d;
    logic [79:0] shadow_q, shadow_d;
    logic [6:0]  idx;
    logic        newbit;

    assign idx    = map_data_i[6:0];
    assign newbit = !brk_q;

    always_comb begin
        state_d   = state_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        clr_d     = clr_q;
        skip_d    = skip_q;
        row_d     = row_q;
        rowbyte_d = rowbyte_q;
        maddr_d   = maddr_q;
        shadow_d  = shadow_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: if (buf_full_q) begin
                pop = 1'b1;
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else begin
                    case (buf_q)
                        8'hE0: ext_d = 1'b1;
                        8'hF0: brk_d = 1'b1;
                        8'hE1: skip_d = 3'd7;
                        8'hFA, 8'hFE: ;
                        default: begin
                            if (buf_q == 8'hAA && !ext_q && !brk_q) begin
                                shadow_d = '0;
                                clr_d    = 1'b1;
                                state_d  = REQ;
                            end else begin
                                maddr_d = {ext_q, buf_q};
                                state_d = LOOKUP;
                            end
                        end
                    endcase
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                state_d = IDLE;
                if (map_data_i[7] && idx < 7'd80 && shadow_q[idx] != newbit) begin
                    shadow_d[idx] = newbit;
                    row_d         = idx[6:3];
                    rowbyte_d     = shadow_d[{idx[6:3], 3'b000} +: 8];
                    state_d       = REQ;
                end
            end
            REQ:    if (bus_gnt_i) state_d = clr_q ? WR_CMT : WR_ROW;
            WR_ROW: state_d = GAP;
            GAP:    state_d = WR_CMT;
            WR_CMT: state_d = DONE;
            DONE: begin
                clr_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge busclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q   <= IDLE;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            clr_q     <= 1'b0;
            skip_q    <= '0;
            row_q     <= '0;
            rowbyte_q <= '0;
            maddr_q   <= '0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            clr_q     <= clr_d;
            skip_q    <= skip_d;
            row_q     <= row_d;
            rowbyte_q <= rowbyte_d;
            maddr_q   <= maddr_d;
            shadow_q  <= shadow_d;
        end
    end

    // Bus outputs decode straight from the state register so reset releases them at once.
    always_comb begin
        bus_req_o = 1'b0;
        A_o       = '0;
        D_o       = '0;
        nWR_o     = 1'b1;
        case (state_q)
            REQ:    bus_req_o = 1'b1;
            WR_ROW: begin bus_req_o = 1'b1; A_o = row_q; D_o = rowbyte_q; nWR_o = 1'b0; end
            GAP:    begin bus_req_o = 1'b1; A_o = row_q; D_o = rowbyte_q; end
            WR_CMT: begin
                bus_req_o = 1'b1;
                A_o       = 4'hA;
                D_o       = clr_q ? 8'h80 : 8'h01;
                nWR_o     = 1'b0;
            end
            default: ;
        endcase
    end

    assign map_addr_o  = maddr_q;
    assign frame_err_o = err_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ps2_keymatrix.sv
// tb/tb_ps2_keymatrix.sv - table-driven, directed and randomized bench for ps2_keymatrix
`timescale 1ns/1ps
module tb_ps2_keymatrix;
    localparam int FL = 8;
    localparam int TO = 600;
    localparam int HP = 20;

    logic       busclk_i = 1'b0;
    logic       nreset_i = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [8:0] map_addr_o;
    logic [7:0] map_data_i;
    logic       bus_req_o;
    logic       bus_gnt_i;
    logic [3:0] A_o;
    logic [7:0] D_o;
    logic       nWR_o, frame_err_o, overflow_o;

    ps2_keymatrix #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .busclk_i(busclk_i), .nreset_i(nreset_i), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .map_addr_o(map_addr_o), .map_data_i(map_data_i), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .A_o(A_o), .D_o(D_o), .nWR_o(nWR_o), .frame_err_o(frame_err_o), .overflow_o(overflow_o)
    );

    always #5 busclk_i = ~busclk_i;

    int checks = 0, errors = 0;
    int cyc = 0, fall_cyc = 0, err_cyc = 0, err_cnt = 0, ovf_cnt = 0;
    logic gnt_rand = 1'b0, gnt_fix = 1'b1;
    logic [7:0] map_rom [512];

    typedef struct { int cyc; logic [3:0] a; logic [7:0] d; logic req; } wr_t;
    typedef struct { logic [3:0] a; logic [7:0] d; } bw_t;
    typedef struct { logic [7:0] pre; logic [7:0] code; int n; logic [3:0] a; logic [7:0] d; logic [8:0] maddr; } vec_t;
    wr_t  wrq[$];
    wr_t  mon_w;
    bw_t  expq[$];
    vec_t vecs[12];

    logic m_sh [80];
    logic m_ext, m_brk;
    int   m_skip;

    always @(posedge busclk_i) cyc <= cyc + 1;
    always @(posedge busclk_i) map_data_i <= map_rom[map_addr_o];
    always @(negedge busclk_i) bus_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_fix;

    always @(negedge busclk_i) begin
        if (nreset_i && !nWR_o) begin
            mon_w.cyc = cyc; mon_w.a = A_o; mon_w.d = D_o; mon_w.req = bus_req_o;
            wrq.push_back(mon_w);
        end
        if (frame_err_o) begin err_cnt++; err_cyc = cyc; end
        if (overflow_o) ovf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 80; i++) m_sh[i] = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    endfunction

    function automatic void push_exp(input int a, input logic [7:0] d);
        bw_t w;
        w.a = 4'(a); w.d = d;
        expq.push_back(w);
    endfunction

    // Behavioural key decoder: flags, shadow array and ordered list of expected bus writes.
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] m, rb;
        int k, row;
        logic nb;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hFA || b == 8'hFE) begin end
        else if (b == 8'hAA && !m_ext && !m_brk) begin
            for (int i = 0; i < 80; i++) m_sh[i] = 1'b0;
            push_exp(10, 8'h80);
        end else begin
            m = map_rom[{m_ext, b}];
            k = int'(m[6:0]);
            nb = !m_brk;
            m_ext = 1'b0; m_brk = 1'b0;
            if (m[7] && k < 80 && m_sh[k] != nb) begin
                m_sh[k] = nb;
                row = k / 8;
                rb = 8'h00;
                for (int j = 0; j < 8; j++) rb[j] = m_sh[row * 8 + j];
                push_exp(row, rb);
                push_exp(10, 8'h01);
            end
        end
    endfunction

    // kind: 0 good, 1 bad parity, 2 bad stop; nbits < 11 truncates the frame
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
        logic [10:0] bits;
        bits = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = bits[i];
            repeat (HP / 2) @(negedge busclk_i);
            ps2_clk_i = 1'b0;
            fall_cyc = cyc;
            repeat (HP) @(negedge busclk_i);
            ps2_clk_i = 1'b1;
            repeat (HP / 2) @(negedge busclk_i);
        end
        ps2_data_i = 1'b1;
        repeat (30) @(negedge busclk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 0, 11);
        model_byte(b);
    endtask

    initial begin
        int e0, o0, found, n;
        logic [31:0] r;
        logic [7:0] b;

        for (int i = 0; i < 512; i++) begin
            r = $urandom;
            map_rom[i] = {r[0] | r[1], 7'(r[15:8] % 90)};
        end
        map_rom[9'h01C] = 8'h80 | 8'd42;
        map_rom[9'h175] = 8'h80 | 8'd3;
        map_rom[9'h075] = 8'h80 | 8'd3;
        map_rom[9'h015] = 8'h00;
        map_rom[9'h016] = 8'h80 | 8'd85;
        map_rom[9'h01A] = 8'h80 | 8'd79;
        map_rom[9'h021] = 8'h80 | 8'd40;
        map_rom[9'h022] = 8'h80 | 8'd41;
        map_rom[9'h023] = 8'h80 | 8'd44;

        vecs[0]  = '{8'h00, 8'h1C, 2, 4'h5, 8'h04, 9'h01C};
        vecs[1]  = '{8'hF0, 8'h1C, 2, 4'h5, 8'h00, 9'h01C};
        vecs[2]  = '{8'hE0, 8'h75, 2, 4'h0, 8'h08, 9'h175};
        vecs[3]  = '{8'hE0, 8'h75, 0, 4'h0, 8'h00, 9'h175};
        vecs[4]  = '{8'h00, 8'h15, 0, 4'h0, 8'h00, 9'h015};
        vecs[5]  = '{8'h00, 8'h16, 0, 4'h0, 8'h00, 9'h016};
        vecs[6]  = '{8'h00, 8'h1A, 2, 4'h9, 8'h80, 9'h01A};
        vecs[7]  = '{8'h00, 8'hFA, 0, 4'h0, 8'h00, 9'h01A};
        vecs[8]  = '{8'hF0, 8'h75, 2, 4'h0, 8'h00, 9'h075};
        vecs[9]  = '{8'h00, 8'hFE, 0, 4'h0, 8'h00, 9'h075};
        vecs[10] = '{8'hF0, 8'hFA, 0, 4'h0, 8'h00, 9'h075};
        vecs[11] = '{8'h00, 8'h1A, 2, 4'h9, 8'h00, 9'h01A};

        model_reset();
        repeat (5) @(negedge busclk_i);
        check("rst_nwr", nWR_o, 1);
        check("rst_req", bus_req_o, 0);
        check("rst_a", A_o, 0);
        check("rst_d", D_o, 0);
        check("rst_maddr", map_addr_o, 0);
        check("rst_err", frame_err_o, 0);
        check("rst_ovf", overflow_o, 0);
        nreset_i = 1'b1;
        repeat (5) @(negedge busclk_i);

        for (int i = 0; i < 12; i++) begin
            wrq.delete();
            if (vecs[i].pre != 8'h00) send_byte(vecs[i].pre);
            send_byte(vecs[i].code);
            check($sformatf("vec%0d_nwrites", i), wrq.size(), vecs[i].n);
            if (vecs[i].n == 2 && wrq.size() == 2) begin
                check($sformatf("vec%0d_row_a", i), wrq[0].a, vecs[i].a);
                check($sformatf("vec%0d_row_d", i), wrq[0].d, vecs[i].d);
                check($sformatf("vec%0d_cmt_a", i), wrq[1].a, 4'hA);
                check($sformatf("vec%0d_cmt_d", i), wrq[1].d, 8'h01);
                check($sformatf("vec%0d_req", i), wrq[0].req & wrq[1].req, 1);
                check($sformatf("vec%0d_gap", i), wrq[1].cyc - wrq[0].cyc, 2);
            end
            check($sformatf("vec%0d_maddr", i), map_addr_o, vecs[i].maddr);
        end
        check("table_no_err", err_cnt, 0);
        expq.delete();

        // frame errors and timeout
        wrq.delete();
        e0 = err_cnt;
        send_frame(8'h1C, 1, 11);
        check("parity_err", err_cnt - e0, 1);
        send_frame(8'h1C, 2, 11);
        check("stop_err", err_cnt - e0, 2);
        send_frame(8'h33, 0, 4);
        for (int k = 0; k < TO + 100 && err_cnt == e0 + 2; k++) @(negedge busclk_i);
        check("timeout_pulse", err_cnt - e0, 3);
        check("timeout_window", ((err_cyc - fall_cyc) >= TO + 2 + FL - 3) && ((err_cyc - fall_cyc) <= TO + 2 + FL + 3), 1);
        check("err_no_writes", wrq.size(), 0);

        // grant withheld: first key waits in REQ, second buffered, third dropped
        gnt_fix = 1'b0;
        o0 = ovf_cnt;
        send_byte(8'h21);
        send_byte(8'h22);
        send_frame(8'h23, 0, 11);
        check("ovf_pulse", ovf_cnt - o0, 1);
        check("ovf_no_writes", wrq.size(), 0);
        check("ovf_req_held", bus_req_o, 1);
        gnt_fix = 1'b1;
        repeat (60) @(negedge busclk_i);
        check("ovf_nwrites", wrq.size(), 4);
        if (wrq.size() == 4) begin
            check("ovf_w0", {wrq[0].a, wrq[0].d}, 12'h501);
            check("ovf_w1", {wrq[1].a, wrq[1].d}, 12'hA01);
            check("ovf_w2", {wrq[2].a, wrq[2].d}, 12'h503);
            check("ovf_w3", {wrq[3].a, wrq[3].d}, 12'hA01);
        end
        check("ovf_req_low", bus_req_o, 0);

        wrq.delete();
        send_byte(8'hAA);
        check("clr_nwrites", wrq.size(), 1);
        if (wrq.size() == 1) check("clr_w", {wrq[0].a, wrq[0].d}, 12'hA80);
        wrq.delete();
        send_byte(8'h1C);
        check("post_clr_nwrites", wrq.size(), 2);
        if (wrq.size() == 2) check("post_clr_row", {wrq[0].a, wrq[0].d}, 12'h504);

        // asynchronous reset in the middle of the row write
        gnt_fix = 1'b0;
        send_byte(8'h21);
        gnt_fix = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge busclk_i);
            if (!nWR_o) found = 1;
        end
        check("wr_row_reached", found, 1);
        #2 nreset_i = 1'b0;
        #1;
        check("arst_nwr", nWR_o, 1);
        check("arst_req", bus_req_o, 0);
        check("arst_a", A_o, 0);
        check("arst_d", D_o, 0);
        repeat (3) @(negedge busclk_i);
        check("arst_maddr", map_addr_o, 0);
        nreset_i = 1'b1;
        model_reset();
        expq.delete();
        repeat (5) @(negedge busclk_i);
        wrq.delete();
        send_byte(8'h1C);
        check("post_rst_nwrites", wrq.size(), 2);
        if (wrq.size() == 2) check("post_rst_row", {wrq[0].a, wrq[0].d}, 12'h504);

        // randomized byte stream against the reference model
        wrq.delete();
        expq.delete();
        e0 = err_cnt;
        o0 = ovf_cnt;
        gnt_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 99);
            if (n < 20) b = 8'hF0;
            else if (n < 32) b = 8'hE0;
            else if (n < 34) b = 8'hAA;
            else if (n < 36) b = 8'hE1;
            else if (n < 38) b = 8'hFA;
            else b = 8'($urandom_range(16, 47));
            send_byte(b);
        end
        repeat (100) @(negedge busclk_i);
        gnt_rand = 1'b0;
        check("rand_nwrites", wrq.size(), expq.size());
        for (int i = 0; i < wrq.size() && i < expq.size(); i++)
            check($sformatf("rand_w%0d", i), {wrq[i].a, wrq[i].d}, {expq[i].a, expq[i].d});
        check("rand_no_err", err_cnt - e0, 0);
        check("rand_no_ovf", ovf_cnt - o0, 0);
        check("rand_req_low", bus_req_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end
endmodule
